tlul_scratch_dev: RTL and testbench
===================================

Name: tlul_scratch_dev

Overview:
- TL-UL device-side responder that sits directly downstream of the access-control wrapper's PMP device port.
- Consumes the filtered host-to-device request stream and produces the device-to-host response that returns to the PMP.
- Implements a small register-backed scratch memory with a single outstanding transaction, error signalling and a saturating error counter.
- Serves as the concrete target for end-to-end PMP checks and for the miter harness.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..64.
- BASE_ADDR, 32'h0000_0000, byte base address; aligned to DEPTH*4.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous active-high reset.
- tl_i  input  tlul_pkg::tl_h2d_t  request from the PMP device port, plus d_ready.
- tl_o  output  tlul_pkg::tl_d2h_t  response to the PMP, plus a_ready.
- err_cnt  output  ERR_CNT_W  count of error responses issued; saturates at all-ones.
- busy  output  1  high while a response is pending (state RESP).

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all memory words go to 0; err_cnt goes to 0.
  - Outputs: a_ready=1, d_valid=0, and every other tl_o field is 0.
- State machine, two states:
  - IDLE: a_ready=1, d_valid=0. When a_valid=1, the request is accepted and the state moves to RESP at the next edge.
  - RESP: a_ready=0, d_valid=1. Leaves for IDLE on the edge where d_ready=1.
  - The response stays stable while d_valid=1 and d_ready=0.
- Latency and throughput:
  - A request accepted at edge N is presented on tl_o at N+1.
  - Single outstanding transaction: at most one accept every 2 cycles.
  - a_ready depends only on state; there is no combinational path from tl_i to a_ready.
- Captured fields on accept: source, size, opcode, a word index taken from address bits [log2(DEPTH)+1:2], and a computed error flag.
- Error conditions (any one sets error):
  - address < BASE_ADDR or address >= BASE_ADDR + DEPTH*4.
  - a_size > 2.
  - address not aligned to 2^a_size.
  - opcode not in {Get=4, PutFullData=0, PutPartialData=1}.
  - PutFullData with a_size=2 and a_mask != 4'hF.
- Write (PutFull/PutPartial, no error):
  - Byte lane b updates at the accept edge iff a_mask[b]=1.
  - A write with a_mask=0 is legal: it is acknowledged and changes nothing.
- Read (Get, no error):
  - d_data is the full stored word at the accepted index, sampled at the accept edge.
  - The value is independent of a_mask.
- Response fields:
  - d_opcode = AccessAckData (1) for Get, AccessAck (0) otherwise.
  - d_size and d_source echo the request; d_param=0, d_sink=0.
  - d_error = error flag.
  - d_data = 0 for writes and for any error.
- Errors:
  - An error never modifies memory.
  - err_cnt increments by 1 on the accept edge of an erroring request and holds at 2^ERR_CNT_W-1.
- Boundaries:
  - a_valid while in RESP is ignored (not accepted) and must be re-presented by the host.
  - d_ready=1 in IDLE has no effect.
  - Back-to-back flow: accept at N, respond N+1 with d_ready=1, accept the next request at N+2.
- Reset mid-operation:
  - A pending response is dropped and d_valid falls immediately (asynchronous).
  - A write accepted on the same edge that rst rises is not performed.
- Reserved user fields in tl_o are driven to 0.

Test Plan:
1. Reset, then PutFullData addr=BASE+0x8, data=0xDEADBEEF, mask=F, source=3 -> at N+1: d_valid=1, d_opcode=0, d_source=3, d_error=0. A following Get at 0x8 returns d_data=0xDEADBEEF, d_opcode=1.
2. PutPartialData at 0x8, mask=4'b0101, data=0x11223344 over 0xDEADBEEF -> a later Get returns 0xDE22BE44. A write with mask=0 leaves the word unchanged and is still acked with d_error=0.
3. Get at BASE+DEPTH*4 (0x40 for DEPTH=16), Get at 0x3 with size=2, and opcode=3 -> each returns d_error=1, d_data=0. err_cnt ends at 3 and memory is unchanged.
4. Response stall: hold d_ready=0 for 5 cycles with a new a_valid=1 -> a_ready=0 throughout, the d_* fields stay constant, and the second request is accepted exactly 1 cycle after d_ready=1.
5. Assert rst while in RESP with d_ready=0 -> d_valid=0 and a_ready=1 in the same cycle; a subsequent Get at 0x8 returns 0; err_cnt=0.
6. Issue 300 erroring requests with ERR_CNT_W=8 -> err_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/tlul_scratch_dev.sv
// TL-UL scratch-memory responder: DEPTH x 32-bit words, one outstanding transaction, saturating error counter.
// Response one cycle after accept; a_ready is low until the response is taken with d_ready.
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_scratch_dev #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  tlul_pkg::tl_h2d_t     tl_i,
    output tlul_pkg::tl_d2h_t     tl_o,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  busy
);
    import tlul_pkg::*;

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_mem [DEPTH];
    logic [2:0]            r_d_opcode;
    logic [1:0]            r_d_size;
    logic [7:0]            r_d_source;
    logic                  r_d_error;
    logic [31:0]           r_d_data;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic                  w_accept;
    logic [AW-1:0]         w_idx;
    logic [32:0]           w_addr33;
    logic [32:0]           w_end;
    logic                  w_range_err;
    logic                  w_size_err;
    logic                  w_align_err;
    logic                  w_op_err;
    logic                  w_mask_err;
    logic                  w_error;
    logic                  w_is_get;
    logic                  w_unused_tl;

    assign w_unused_tl = ^{tl_i.a_param, tl_i.a_user};

    assign w_accept    = (r_state == IDLE) && tl_i.a_valid;
    assign w_idx       = tl_i.a_address[AW+1:2];
    assign w_addr33    = {1'b0, tl_i.a_address};
    // 33-bit end bound so a window ending at 4 GiB does not wrap
    assign w_end       = {1'b0, BASE_ADDR} + 33'(DEPTH * 4);
    assign w_range_err = (w_addr33 < {1'b0, BASE_ADDR}) || (w_addr33 >= w_end);
    assign w_size_err  = (tl_i.a_size == 2'd3);
    assign w_is_get    = (tl_i.a_opcode == Get);
    assign w_op_err    = !(tl_i.a_opcode inside {Get, PutFullData, PutPartialData});
    assign w_mask_err  = (tl_i.a_opcode == PutFullData) && (tl_i.a_size == 2'd2)
                         && (tl_i.a_mask != 4'hF);
    assign w_error     = w_range_err || w_size_err || w_align_err || w_op_err || w_mask_err;

    always_comb begin
        w_align_err = 1'b0;
        case (tl_i.a_size)
            2'd1:    w_align_err = tl_i.a_address[0];
            2'd2:    w_align_err = |tl_i.a_address[1:0];
            default: w_align_err = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (tl_i.a_valid) w_state_nxt = RESP;
            RESP:    if (tl_i.d_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && !w_error && !w_is_get) begin
            for (int b = 0; b < 4; b++) begin
                if (tl_i.a_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
                end
            end
        end
    end

    // Response fields are captured at accept and held until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_error  <= 1'b0;
            r_d_data   <= '0;
            r_err_cnt  <= '0;
        end else if (w_accept) begin
            r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_error  <= w_error;
            r_d_data   <= (w_is_get && !w_error) ? r_mem[w_idx] : 32'h0;
            if (w_error && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (r_state == IDLE);
        tl_o.d_valid  = (r_state == RESP);
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_size   = r_d_size;
        tl_o.d_source = r_d_source;
        tl_o.d_error  = r_d_error;
        tl_o.d_data   = r_d_data;
    end

    assign err_cnt = r_err_cnt;
    assign busy    = (r_state == RESP);
endmodule

// File: tb/tb_tlul_scratch_dev.sv
// Scoreboard bench for tlul_scratch_dev: stimulus pushes expected responses, a monitor pops them on each d handshake.
module tb_tlul_scratch_dev;
    logic              clk = 1'b0;
    logic              rst;
    tlul_pkg::tl_h2d_t tl_i;
    tlul_pkg::tl_d2h_t tl_o;
    logic [7:0]        err_cnt;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic        err;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    tlul_scratch_dev #(.DEPTH(16), .BASE_ADDR(32'h0), .ERR_CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && tl_o.d_valid && tl_i.d_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp", {tl_o.d_opcode, tl_o.d_error, tl_o.d_size, tl_o.d_source,
                             tl_o.d_data, tl_o.d_param, tl_o.d_sink},
                            {mon_e, 3'b000, 1'b0});
            end
        end
    end

    task automatic push_exp(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                            input logic err, input logic [31:0] data);
        exp_t e;
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.err  = err;
        e.size = size;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_size    = size;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                          input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                          input logic exp_err, input logic [31:0] exp_data, input bit push);
        logic acc;
        acc = 1'b0;
        if (push) push_exp(op, size, src, exp_err, exp_data);
        drive(op, addr, size, mask, data, src);
        for (int i = 0; i < 20; i++) begin
            acc = tl_o.a_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        tl_i.a_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !tl_o.d_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 64'(tl_o.a_ready), 64'd1);
        chk("rst_d_valid", 64'(tl_o.d_valid), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_d_data",  64'(tl_o.d_data), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read back
        do_req(3'd0, 32'h8, 2'd2, 4'hF, 32'hDEADBEEF, 8'd3, 1'b0, 32'h0, 1'b1);
        chk("t1_d_valid", 64'(tl_o.d_valid), 64'd1);
        chk("t1_a_ready", 64'(tl_o.a_ready), 64'd0);
        chk("t1_busy",    64'(busy), 64'd1);
        do_req(3'd4, 32'h8, 2'd2, 4'h0, 32'h0, 8'd4, 1'b0, 32'hDEADBEEF, 1'b1);
        drain();

        // Partial write, zero-mask write
        do_req(3'd1, 32'h8, 2'd2, 4'b0101, 32'h11223344, 8'd1, 1'b0, 32'h0, 1'b1);
        do_req(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd2, 1'b0, 32'hDE22BE44, 1'b1);
        do_req(3'd1, 32'h8, 2'd2, 4'h0, 32'hFFFFFFFF, 8'd2, 1'b0, 32'h0, 1'b1);
        do_req(3'd4, 32'h8, 2'd2, 4'h1, 32'h0, 8'd7, 1'b0, 32'hDE22BE44, 1'b1);
        drain();

        // Error cases
        do_req(3'd4, 32'h40, 2'd2, 4'hF, 32'h0, 8'd8, 1'b1, 32'h0, 1'b1);
        do_req(3'd4, 32'h3,  2'd2, 4'hF, 32'h0, 8'd9, 1'b1, 32'h0, 1'b1);
        do_req(3'd3, 32'h8,  2'd2, 4'hF, 32'hCAFEF00D, 8'd10, 1'b1, 32'h0, 1'b1);
        drain();
        chk("t3_err_cnt", 64'(err_cnt), 64'd3);
        do_req(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd11, 1'b0, 32'hDE22BE44, 1'b1);
        drain();

        // Response stall with a second request waiting
        tl_i.d_ready = 1'b0;
        do_req(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd5, 1'b0, 32'hDE22BE44, 1'b1);
        push_exp(3'd4, 2'd2, 8'd6, 1'b0, 32'hDE22BE44);
        drive(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd6);
        for (int i = 0; i < 5; i++) begin
            chk("stall_a_ready",  64'(tl_o.a_ready), 64'd0);
            chk("stall_d_data",   64'(tl_o.d_data), 64'hDE22BE44);
            chk("stall_d_source", 64'(tl_o.d_source), 64'd5);
            @(posedge clk);
            #1;
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_a_ready", 64'(tl_o.a_ready), 64'd1);
        chk("release_d_valid", 64'(tl_o.d_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("second_accept_valid",  64'(tl_o.d_valid), 64'd1);
        chk("second_accept_source", 64'(tl_o.d_source), 64'd6);
        tl_i.a_valid = 1'b0;
        drain();

        // Reset while a response is pending
        tl_i.d_ready = 1'b0;
        do_req(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd12, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_d_valid", 64'(tl_o.d_valid), 64'd0);
        chk("midrst_a_ready", 64'(tl_o.a_ready), 64'd1);
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tl_i.d_ready = 1'b1;
        do_req(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'd13, 1'b0, 32'h0, 1'b1);
        drain();

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            do_req(3'd3, 32'h8, 2'd2, 4'hF, 32'h0, 8'(i), 1'b1, 32'h0, 1'b1);
            if (i == 253) chk("err_cnt_254", 64'(err_cnt), 64'd254);
            if (i == 254) chk("err_cnt_255", 64'(err_cnt), 64'd255);
        end
        drain();
        chk("err_cnt_sat", 64'(err_cnt), 64'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
